// File: rtl/bfp16_pkg.sv
// Shared types for the BFP16 operand stream merge slice.
package bfp16_pkg;

   localparam int BFP16_W = 16;

   typedef logic [BFP16_W-1:0] bfp16_t;

   typedef enum logic [1:0] {
      IDLE,
      LOCK0,
      LOCK1
   } merge_state_t;

endpackage

// File: rtl/bfp16_rr_arb.sv
// Round-robin 2:1 arbiter with atomic bursts of BURST_LEN beats.
module bfp16_rr_arb
   import bfp16_pkg::*;
#(
   parameter int BURST_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic v0_i,
   input  logic v1_i,
   input  logic load_en_i,
   output logic grant_o,
   output logic burst_active_o
);

   merge_state_t state_q, state_d;
   logic [7:0]   beat_cnt_q, beat_cnt_d;
   logic         last_src_q, last_src_d;
   logic         accept;
   logic [7:0]   last_beat;

   assign last_beat = 8'(BURST_LEN - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         last_src_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         last_src_q <= last_src_d;
      end
   end

   // A locked burst keeps the grant even while its owner is idle.
   always_comb begin
      grant_o = last_src_q;
      unique case (state_q)
         LOCK0:   grant_o = 1'b0;
         LOCK1:   grant_o = 1'b1;
         default: begin
            if (v0_i && v1_i) grant_o = !last_src_q;
            else if (v0_i)    grant_o = 1'b0;
            else if (v1_i)    grant_o = 1'b1;
         end
      endcase
      burst_active_o = (state_q != IDLE);
   end

   assign accept = load_en_i & (grant_o ? v1_i : v0_i);

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      last_src_d = last_src_q;
      if (accept) begin
         if (state_q == IDLE) begin
            if (BURST_LEN == 1) begin
               last_src_d = grant_o;
            end else begin
               state_d    = grant_o ? LOCK1 : LOCK0;
               beat_cnt_d = 8'd1;
            end
         end else if (beat_cnt_q == last_beat) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            last_src_d = grant_o;
         end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: rtl/bfp16_stream_merge.sv
// 2:1 BFP16 stream merge: round-robin burst arbiter feeding one
// registered, source-tagged output stage.
module bfp16_stream_merge
   import bfp16_pkg::*;
#(
   parameter int DATA_TYPE = BFP16_W,
   parameter int BURST_LEN = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_TYPE-1:0] in0_data,
   input  logic                 in0_valid,
   output logic                 in0_ready,
   input  logic [DATA_TYPE-1:0] in1_data,
   input  logic                 in1_valid,
   output logic                 in1_ready,
   output logic [DATA_TYPE-1:0] out_data,
   output logic                 out_src,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 burst_active
);

   logic                 load_en;
   logic                 grant;
   logic                 acc0, acc1;
   logic [DATA_TYPE-1:0] out_data_q, out_data_d;
   logic                 out_src_q, out_src_d;
   logic                 out_valid_q, out_valid_d;

   bfp16_rr_arb #(
      .BURST_LEN (BURST_LEN)
   ) u_arb (
      .clk            (clk),
      .rst_n          (rst_n),
      .v0_i           (in0_valid),
      .v1_i           (in1_valid),
      .load_en_i      (load_en),
      .grant_o        (grant),
      .burst_active_o (burst_active)
   );

   assign load_en   = !out_valid_q | out_ready;
   assign in0_ready = load_en & ~grant;
   assign in1_ready = load_en & grant;
   assign acc0      = in0_valid & in0_ready;
   assign acc1      = in1_valid & in1_ready;

   // Defaults hold the register, which is exactly the stall behaviour.
   always_comb begin
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      if (load_en) begin
         out_valid_d = acc0 | acc1;
         if (acc1) begin
            out_data_d = in1_data;
            out_src_d  = 1'b1;
         end else if (acc0) begin
            out_data_d = in0_data;
            out_src_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_src_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

endmodule
